// File: rtl/wb_sched_pkg.sv
// ============================================================================
// Module      : wb_sched_pkg
// Description : Shared definitions for the ZC-RISCV writeback scheduler.
//               Holds the register index width macro, the register count and
//               the producer-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ZCRV_REG_SIZE
`define ZCRV_REG_SIZE 5
`endif

package wb_sched_pkg;

   localparam int unsigned REG_W    = `ZCRV_REG_SIZE;
   localparam int unsigned NUM_REGS = 32;

   // Which producer owns the write port this cycle
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LSU  = 2'd2,
      SEL_MDU  = 2'd3
   } wb_sel_e;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module      : wb_scoreboard
// Description : Pending-destination scoreboard for long-latency ops (loads,
//               mul/div). One pending bit per register, x0 never pending.
//               Raises stall_id on RAW (rs1/rs2) or WAW (issue_rd) hazards.
// Ports       : clk, rst_n        - clock, async active-low reset
//               issue_*           - instruction issue from ID
//               id_rs*/id_rs*_en  - ID source operands
//               clr_en, clr_rd    - LSU/MDU writeback transfer
//               stall_id          - decode stall (from registered state only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ZCRV_REG_SIZE
`define ZCRV_REG_SIZE 5
`endif

module wb_scoreboard
   import wb_sched_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      issue_en,
   input  logic [`ZCRV_REG_SIZE-1:0] issue_rd,
   input  logic                      issue_long,
   input  logic [`ZCRV_REG_SIZE-1:0] id_rs1,
   input  logic [`ZCRV_REG_SIZE-1:0] id_rs2,
   input  logic                      id_rs1_en,
   input  logic                      id_rs2_en,
   input  logic                      clr_en,
   input  logic [`ZCRV_REG_SIZE-1:0] clr_rd,
   output logic                      stall_id
);

   logic [NUM_REGS-1:1] r_pending;
   logic [NUM_REGS-1:0] w_pending;
   logic [NUM_REGS-1:1] w_set_mask;
   logic [NUM_REGS-1:1] w_clr_mask;
   logic                w_set_en;
   logic                w_stall;

   // Bit 0 is tied low so x0 never stalls anything
   assign w_pending = {r_pending, 1'b0};

   assign w_stall = (id_rs1_en & w_pending[id_rs1])
                  | (id_rs2_en & w_pending[id_rs2])
                  | (issue_en  & w_pending[issue_rd]);

   assign w_set_en = issue_en & issue_long & ~w_stall & (issue_rd != '0);

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         w_set_mask[i] = w_set_en & (issue_rd == REG_W'(i));
         w_clr_mask[i] = clr_en   & (clr_rd   == REG_W'(i));
      end
   end

   // Set is applied after clear, so a same-index collision keeps the bit set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      end
   end

   assign stall_id = w_stall;

endmodule

`default_nettype wire

// File: rtl/wb_sched.sv
// ============================================================================
// Module      : wb_sched
// Description : Writeback scheduler. Arbitrates the single register-file
//               write port between ALU > LSU > MDU (fixed priority), registers
//               the winner onto the WB port and drives the scoreboard.
//               Optional macro ZCRV_WB_AGE_EN adds an MDU starvation counter
//               that masks the LSU for one cycle at STARVE_LIMIT.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               issue_*, id_rs*            - ID issue / source operands
//               stall_id                   - decode stall
//               alu_*, lsu_*, mdu_*        - producer result channels
//               rd_en_to_wb, rd_to_wb,
//               rddata_to_wb               - registered WB write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ZCRV_REG_SIZE
`define ZCRV_REG_SIZE 5
`endif

module wb_sched
   import wb_sched_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      issue_en,
   input  logic [`ZCRV_REG_SIZE-1:0] issue_rd,
   input  logic                      issue_long,
   input  logic [`ZCRV_REG_SIZE-1:0] id_rs1,
   input  logic [`ZCRV_REG_SIZE-1:0] id_rs2,
   input  logic                      id_rs1_en,
   input  logic                      id_rs2_en,
   output logic                      stall_id,
   input  logic                      alu_valid,
   input  logic [`ZCRV_REG_SIZE-1:0] alu_rd,
   input  logic [31:0]               alu_data,
   input  logic                      lsu_valid,
   input  logic [`ZCRV_REG_SIZE-1:0] lsu_rd,
   input  logic [31:0]               lsu_data,
   output logic                      lsu_ready,
   input  logic                      mdu_valid,
   input  logic [`ZCRV_REG_SIZE-1:0] mdu_rd,
   input  logic [31:0]               mdu_data,
   output logic                      mdu_ready,
   output logic                      rd_en_to_wb,
   output logic [`ZCRV_REG_SIZE-1:0] rd_to_wb,
   output logic [31:0]               rddata_to_wb
);

   wb_sel_e                   w_sel;
   logic [`ZCRV_REG_SIZE-1:0] w_rd;
   logic [31:0]               w_data;
   logic                      w_lsu_mask;
   logic                      r_rd_en;
   logic [`ZCRV_REG_SIZE-1:0] r_rd;
   logic [31:0]               r_data;

   // A zero limit would mask the LSU on every cycle the MDU waits
   if (STARVE_LIMIT < 1) begin : g_limit_degenerate
   end

`ifdef ZCRV_WB_AGE_EN
   localparam int unsigned c_cnt_w = $clog2(STARVE_LIMIT + 1);

   logic [c_cnt_w-1:0] r_starve;

   // Saturates at the limit so the mask persists while the ALU keeps winning
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (mdu_valid && mdu_ready) begin
         r_starve <= '0;
      end else if (mdu_valid && (r_starve != c_cnt_w'(STARVE_LIMIT))) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   assign w_lsu_mask = (r_starve == c_cnt_w'(STARVE_LIMIT));
`else
   assign w_lsu_mask = 1'b0;
`endif

   // Grant: ALU is never backpressured, LSU/MDU only see ready when it's idle
   assign lsu_ready = lsu_valid & ~alu_valid & ~w_lsu_mask;
   assign mdu_ready = mdu_valid & ~alu_valid & ~lsu_ready;

   always_comb begin
      w_sel  = SEL_NONE;
      w_rd   = '0;
      w_data = '0;
      if (alu_valid) begin
         w_sel  = SEL_ALU;
         w_rd   = alu_rd;
         w_data = alu_data;
      end else if (lsu_ready) begin
         w_sel  = SEL_LSU;
         w_rd   = lsu_rd;
         w_data = lsu_data;
      end else if (mdu_ready) begin
         w_sel  = SEL_MDU;
         w_rd   = mdu_rd;
         w_data = mdu_data;
      end
   end

   // WB register: rd/data only reload on a grant, enable drops otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         r_rd_en <= (w_sel != SEL_NONE) && (w_rd != '0);
         if (w_sel != SEL_NONE) begin
            r_rd   <= w_rd;
            r_data <= w_data;
         end
      end
   end

   assign rd_en_to_wb  = r_rd_en;
   assign rd_to_wb     = r_rd;
   assign rddata_to_wb = r_data;

   // Long-op destinations retire on the same edge the WB register loads them
   wb_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_en   (issue_en),
      .issue_rd   (issue_rd),
      .issue_long (issue_long),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rs1_en  (id_rs1_en),
      .id_rs2_en  (id_rs2_en),
      .clr_en     ((w_sel == SEL_LSU) || (w_sel == SEL_MDU)),
      .clr_rd     (w_rd),
      .stall_id   (stall_id)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_sched.sv
// ============================================================================
// Module      : tb_wb_sched
// Description : Self-checking bench for wb_sched. Grant/WB behaviour from a
//               vector table, plus directed multi-cycle sequences for the
//               scoreboard, priority drain, reset and starvation aging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_en, issue_long, id_rs1_en, id_rs2_en;
   logic [4:0]  issue_rd, id_rs1, id_rs2;
   logic        stall_id;
   logic        alu_valid, lsu_valid, mdu_valid;
   logic [4:0]  alu_rd, lsu_rd, mdu_rd;
   logic [31:0] alu_data, lsu_data, mdu_data;
   logic        lsu_ready, mdu_ready;
   logic        rd_en_to_wb;
   logic [4:0]  rd_to_wb;
   logic [31:0] rddata_to_wb;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_sched #(.STARVE_LIMIT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_en     (issue_en),
      .issue_rd     (issue_rd),
      .issue_long   (issue_long),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_en    (id_rs1_en),
      .id_rs2_en    (id_rs2_en),
      .stall_id     (stall_id),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .mdu_valid    (mdu_valid),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .mdu_ready    (mdu_ready),
      .rd_en_to_wb  (rd_en_to_wb),
      .rd_to_wb     (rd_to_wb),
      .rddata_to_wb (rddata_to_wb)
   );

   typedef struct {
      logic        av; logic [4:0] ard; logic [31:0] ad;
      logic        lv; logic [4:0] lrd; logic [31:0] ld;
      logic        mv; logic [4:0] mrd; logic [31:0] md;
      logic        e_lr; logic e_mr; logic e_en; logic [4:0] e_rd; logic [31:0] e_d;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      issue_en = 0; issue_long = 0; issue_rd = 0;
      id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // av ard ad           lv lrd ld            mv mrd md            lr mr en rd  d
      tbl[0] = '{1, 3,  32'h11,       0, 0,  0,           0, 0,  0,           0, 0, 1, 3,  32'h11};
      tbl[1] = '{0, 0,  0,            1, 4,  32'h22,      0, 0,  0,           1, 0, 1, 4,  32'h22};
      tbl[2] = '{0, 0,  0,            0, 0,  0,           1, 6,  32'h33,      0, 1, 1, 6,  32'h33};
      tbl[3] = '{0, 0,  0,            1, 8,  32'h44,      1, 9,  32'h55,      1, 0, 1, 8,  32'h44};
      tbl[4] = '{1, 1,  32'h66,       1, 8,  32'h44,      1, 9,  32'h55,      0, 0, 1, 1,  32'h66};
      tbl[5] = '{1, 2,  32'h77,       0, 0,  0,           1, 9,  32'h55,      0, 0, 1, 2,  32'h77};
      tbl[6] = '{0, 0,  0,            0, 0,  0,           0, 0,  0,           0, 0, 0, 0,  0};
      tbl[7] = '{1, 0,  32'hDEADBEEF, 0, 0,  0,           0, 0,  0,           0, 0, 0, 0,  0};
      tbl[8] = '{0, 0,  0,            1, 0,  32'hDEADBEEF,0, 0,  0,           1, 0, 0, 0,  0};
      tbl[9] = '{0, 0,  0,            0, 0,  0,           1, 31, 32'hFFFFFFFF,0, 1, 1, 31, 32'hFFFFFFFF};

      // ---- reset with every input active ----
      rst_n = 0;
      idle_all();
      issue_en = 1; issue_long = 1; issue_rd = 5;
      alu_valid = 1; alu_rd = 3; alu_data = 32'hA1A1A1A1;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hB2;
      mdu_valid = 1; mdu_rd = 6; mdu_data = 32'hC3;
      step(); step();
      chk("rst_rd_en", {31'b0, rd_en_to_wb}, 0);
      chk("rst_rd", {27'b0, rd_to_wb}, 0);
      chk("rst_data", rddata_to_wb, 0);
      chk("rst_stall", {31'b0, stall_id}, 0);
      chk("rst_lsu_ready", {31'b0, lsu_ready}, 0);
      chk("rst_mdu_ready", {31'b0, mdu_ready}, 0);
      issue_en = 0; issue_long = 0; lsu_valid = 0; mdu_valid = 0;
      rst_n = 1;
      step();
      chk("rel_rd_en", {31'b0, rd_en_to_wb}, 1);
      chk("rel_rd", {27'b0, rd_to_wb}, 3);
      chk("rel_data", rddata_to_wb, 32'hA1A1A1A1);
      idle_all();
      step();

      // ---- table-driven grant/WB vectors ----
      for (int i = 0; i < 10; i++) begin
         alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
         lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
         mdu_valid = tbl[i].mv; mdu_rd = tbl[i].mrd; mdu_data = tbl[i].md;
         #1;
         chk($sformatf("v%0d_lsu_ready", i), {31'b0, lsu_ready}, {31'b0, tbl[i].e_lr});
         chk($sformatf("v%0d_mdu_ready", i), {31'b0, mdu_ready}, {31'b0, tbl[i].e_mr});
         step();
         chk($sformatf("v%0d_rd_en", i), {31'b0, rd_en_to_wb}, {31'b0, tbl[i].e_en});
         if (tbl[i].e_en) begin
            chk($sformatf("v%0d_rd", i), {27'b0, rd_to_wb}, {27'b0, tbl[i].e_rd});
            chk($sformatf("v%0d_data", i), rddata_to_wb, tbl[i].e_d);
         end
      end
      idle_all();
      step();

      // ---- load x5 then RAW on rs1 ----
      issue_en = 1; issue_long = 1; issue_rd = 5;
      #1 chk("ld_no_self_stall", {31'b0, stall_id}, 0);
      step();
      issue_en = 0; issue_long = 0; id_rs1 = 5; id_rs1_en = 1;
      #1 chk("raw_stall_c1", {31'b0, stall_id}, 1);
      step();
      chk("raw_stall_c2", {31'b0, stall_id}, 1);
      lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hCAFE0005;
      #1 chk("raw_stall_xfer", {31'b0, stall_id}, 1);
      chk("raw_lsu_ready", {31'b0, lsu_ready}, 1);
      step();
      lsu_valid = 0;
      #1 chk("raw_stall_clear", {31'b0, stall_id}, 0);
      chk("raw_wb_en", {31'b0, rd_en_to_wb}, 1);
      chk("raw_wb_rd", {27'b0, rd_to_wb}, 5);
      chk("raw_wb_data", rddata_to_wb, 32'hCAFE0005);
      idle_all();
      step();

      // ---- priority drain: all valid 3 cycles, then ALU drops ----
      alu_valid = 1; alu_rd = 11; alu_data = 32'hA;
      lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hB;
      mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hC;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("drain_alu_lr", {31'b0, lsu_ready}, 0);
         chk("drain_alu_mr", {31'b0, mdu_ready}, 0);
         step();
         chk("drain_alu_rd", {27'b0, rd_to_wb}, 11);
      end
      alu_valid = 0;
      #1 chk("drain_lsu_lr", {31'b0, lsu_ready}, 1);
      chk("drain_lsu_mr", {31'b0, mdu_ready}, 0);
      step();
      chk("drain_lsu_rd", {27'b0, rd_to_wb}, 12);
      chk("drain_lsu_data", rddata_to_wb, 32'hB);
      lsu_valid = 0;
      #1 chk("drain_mdu_lr", {31'b0, lsu_ready}, 0);
      chk("drain_mdu_mr", {31'b0, mdu_ready}, 1);
      step();
      chk("drain_mdu_rd", {27'b0, rd_to_wb}, 13);
      mdu_valid = 0;
      #1 chk("drain_end_mr", {31'b0, mdu_ready}, 0);
      step();
      chk("drain_end_en", {31'b0, rd_en_to_wb}, 0);
      idle_all();

      // ---- WAW: MDU to x7, then ALU op to x7 ----
      issue_en = 1; issue_long = 1; issue_rd = 7;
      #1 chk("waw_issue_nostall", {31'b0, stall_id}, 0);
      step();
      issue_long = 0;
      #1 chk("waw_stall_c1", {31'b0, stall_id}, 1);
      step();
      chk("waw_stall_c2", {31'b0, stall_id}, 1);
      mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h00000777;
      #1 chk("waw_mdu_ready", {31'b0, mdu_ready}, 1);
      chk("waw_stall_xfer", {31'b0, stall_id}, 1);
      step();
      mdu_valid = 0;
      #1 chk("waw_stall_clear", {31'b0, stall_id}, 0);
      chk("waw_wb_rd", {27'b0, rd_to_wb}, 7);
      chk("waw_wb_data", rddata_to_wb, 32'h00000777);
      idle_all();
      step();

      // ---- x0 never pending; write to x0 suppressed but accepted ----
      issue_en = 1; issue_long = 1; issue_rd = 0;
      step();
      issue_long = 0; id_rs1 = 0; id_rs1_en = 1;
      mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hDEADBEEF;
      #1 chk("x0_no_stall", {31'b0, stall_id}, 0);
      chk("x0_mdu_ready", {31'b0, mdu_ready}, 1);
      step();
      chk("x0_rd_en", {31'b0, rd_en_to_wb}, 0);
      idle_all();
      step();

      // ---- asynchronous reset mid-operation ----
      issue_en = 1; issue_long = 1; issue_rd = 10;
      step();
      issue_en = 0; issue_long = 0; id_rs2 = 10; id_rs2_en = 1;
      alu_valid = 1; alu_rd = 2; alu_data = 32'h12345678;
      #1 chk("mid_stall_before", {31'b0, stall_id}, 1);
      step();
      chk("mid_wb_before", {31'b0, rd_en_to_wb}, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_stall", {31'b0, stall_id}, 0);
      chk("mid_rst_en", {31'b0, rd_en_to_wb}, 0);
      chk("mid_rst_data", rddata_to_wb, 0);
      alu_valid = 0;
      step();
      rst_n = 1;
      #1 chk("mid_after_stall", {31'b0, stall_id}, 0);
      idle_all();
      step();

      // ---- MDU behind a continuously valid LSU ----
      lsu_valid = 1; lsu_rd = 14; lsu_data = 32'hE;
      mdu_valid = 1; mdu_rd = 15; mdu_data = 32'hF;
`ifdef ZCRV_WB_AGE_EN
      for (int k = 1; k <= 9; k++) begin
         #1;
         chk($sformatf("age_k%0d_lr", k), {31'b0, lsu_ready}, (k < 9) ? 32'd1 : 32'd0);
         chk($sformatf("age_k%0d_mr", k), {31'b0, mdu_ready}, (k < 9) ? 32'd0 : 32'd1);
         step();
      end
      chk("age_wb_rd", {27'b0, rd_to_wb}, 15);
      mdu_valid = 0;
      #1 chk("age_lsu_back", {31'b0, lsu_ready}, 1);
`else
      for (int k = 1; k <= 12; k++) begin
         #1;
         chk($sformatf("strict_k%0d_mr", k), {31'b0, mdu_ready}, 0);
         step();
      end
      chk("strict_wb_rd", {27'b0, rd_to_wb}, 14);
`endif
      idle_all();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
